// File: rtl/mult_seq32.sv
// Sequential 32x32 shift-add multiplier: IDLE -> RUN (32 cycles) -> FIX -> DONE.
// Define MULT_SEQ32_SIGNED_EN to honour SIGNED; otherwise every operation is unsigned.
module mult_seq32 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [5:0]         cnt;
  logic               neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] fixed;

`ifdef MULT_SEQ32_SIGNED_EN
  logic neg_next;

  // Negating the most negative value yields itself, which is the correct unsigned magnitude.
  always_comb begin
    mag_a    = (SIGNED && A[WIDTH-1]) ? -A : A;
    mag_b    = (SIGNED && B[WIDTH-1]) ? -B : B;
    neg_next = SIGNED && (A[WIDTH-1] ^ B[WIDTH-1]);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      neg <= 1'b0;
    else if (START && !BUSY)
      neg <= neg_next;
  end

  assign fixed = neg ? -product : product;
`else
  logic unused_signed;

  assign unused_signed = SIGNED;
  assign mag_a         = A;
  assign mag_b         = B;
  assign neg           = 1'b0;
  assign fixed         = product;
`endif

  assign sum     = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign product = {acc, mq};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            mcand <= mag_a;
            acc   <= '0;
            mq    <= mag_b;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          // {carry, acc, mq} shifted right by one; the retired multiplier bit falls off mq.
          acc <= sum[WIDTH:1];
          mq  <= {sum[0], mq[WIDTH-1:1]};
          cnt <= cnt + 6'd1;
          if (cnt == 6'(WIDTH - 1))
            state <= S_FIX;
        end
        S_FIX: begin
          HI    <= fixed[2*WIDTH-1:WIDTH];
          LO    <= fixed[WIDTH-1:0];
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = (state == S_RUN) || (state == S_FIX);
  assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_mult_seq32.sv
// Self-checking bench for mult_seq32: directed boundary cases, randomized operands
// against an arithmetic reference, busy-ignore, mid-operation reset and back-to-back starts.
module tb_mult_seq32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  mult_seq32 #(.WIDTH(32)) dut (
    .CLK(clk), .RESET(rst_n), .START(start), .SIGNED(sgn),
    .A(a), .B(b), .HI(hi), .LO(lo), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // Reference product from plain arithmetic on the operand values.
  function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
    logic   use_signed;
    longint sa;
    longint sb;
    use_signed = ms;
`ifndef MULT_SEQ32_SIGNED_EN
    use_signed = 1'b0;
`endif
    if (use_signed) begin
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      return 64'(sa * sb);
    end
    return {32'b0, ma} * {32'b0, mb};
  endfunction

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
    @(negedge clk);
    a = ta; b = tb_v; sgn = ts; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles (negedges) after the accepting edge until DONE is seen; -1 on timeout.
  task automatic wait_done(output int cycles, output logic hilo_moved);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = hi; l0 = lo; hilo_moved = 1'b0; cycles = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        cycles = n;
        return;
      end
      if (hi !== h0 || lo !== l0) hilo_moved = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [2] = '{32'h3, 32'hFFFFFFFF};
    logic [31:0] tb_v [2] = '{32'h5, 32'hFFFFFFFF};
    logic [63:0] exp_p [2] = '{64'h0000000F, 64'hFFFFFFFE_00000001};
    int   cycles;
    logic moved;
    for (int i = 0; i < 2; i++) begin
      start_op(ta[i], tb_v[i], 1'b0);
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL dir_busy[%0d]: got %b expected 1", i, busy); end
      wait_done(cycles, moved);
      tests_run++; if (cycles !== 34) begin tests_failed++; $display("[TB] FAIL dir_latency[%0d]: got %0d expected 34", i, cycles); end
      tests_run++; if ({hi, lo} !== exp_p[i]) begin tests_failed++; $display("[TB] FAIL dir_product[%0d]: got %h expected %h", i, {hi, lo}, exp_p[i]); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL dir_busy_done[%0d]: got %b expected 0", i, busy); end
      @(negedge clk);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL dir_pulse[%0d]: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_signed();
    logic [31:0] ta [4] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFB};
    logic [31:0] tb_v [4] = '{32'h00000007, 32'h80000000, 32'hFFFFFFFB, 32'h00000000};
`ifdef MULT_SEQ32_SIGNED_EN
    logic [63:0] exp_p [4] = '{64'hFFFFFFFF_FFFFFFF9, 64'h40000000_00000000, 64'h0, 64'h0};
`else
    logic [63:0] exp_p [4] = '{64'h00000006_FFFFFFF9, 64'h40000000_00000000, 64'h0, 64'h0};
`endif
    int   cycles;
    logic moved;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb_v[i], 1'b1);
      wait_done(cycles, moved);
      tests_run++; if (cycles !== 34) begin tests_failed++; $display("[TB] FAIL sgn_latency[%0d]: got %0d expected 34", i, cycles); end
      tests_run++; if ({hi, lo} !== exp_p[i]) begin tests_failed++; $display("[TB] FAIL sgn_product[%0d]: got %h expected %h", i, {hi, lo}, exp_p[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] exp_p;
    int          cycles;
    logic        moved;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = 32'h0;
        2: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h80000000;
        1: rb = 32'h1;
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      exp_p = model(ra, rb, rs);
      start_op(ra, rb, rs);
      wait_done(cycles, moved);
      tests_run++; if (cycles !== 34) begin tests_failed++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected 34", i, cycles); end
      tests_run++; if (moved !== 1'b0) begin tests_failed++; $display("[TB] FAIL rnd_hilo_stable[%0d]: got %b expected 0", i, moved); end
      tests_run++; if ({hi, lo} !== exp_p) begin tests_failed++; $display("[TB] FAIL rnd_product[%0d] a=%h b=%h s=%b: got %h expected %h", i, ra, rb, rs, {hi, lo}, exp_p); end
    end
  endtask

  task automatic test_busy_ignore();
    int          done_count = 0;
    int          done_at = -1;
    int          busy_low_early = 0;
    logic [63:0] cap = '0;
    start_op(32'd2, 32'd2, 1'b0);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (done) begin
        done_count++;
        if (done_at < 0) begin done_at = n; cap = {hi, lo}; end
      end
      if (n < 34 && !busy) busy_low_early++;
      if (n == 10) begin a = 32'd9; b = 32'd9; start = 1'b1; end
      if (n == 11) start = 1'b0;
    end
    tests_run++; if (done_count !== 1) begin tests_failed++; $display("[TB] FAIL busy_done_count: got %0d expected 1", done_count); end
    tests_run++; if (done_at !== 34) begin tests_failed++; $display("[TB] FAIL busy_latency: got %0d expected 34", done_at); end
    tests_run++; if (cap !== 64'h4) begin tests_failed++; $display("[TB] FAIL busy_product: got %h expected 4", cap); end
    tests_run++; if (busy_low_early !== 0) begin tests_failed++; $display("[TB] FAIL busy_held: got %0d expected 0", busy_low_early); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_reset_abort();
    int   stray = 0;
    int   cycles;
    logic moved;
    start_op(32'd6, 32'd7, 1'b0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++; if ({hi, lo} !== 64'h0) begin tests_failed++; $display("[TB] FAIL abort_hilo: got %h expected 0", {hi, lo}); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    tests_run++; if (stray !== 0) begin tests_failed++; $display("[TB] FAIL abort_idle: got %0d active cycles expected 0", stray); end
    start_op(32'd6, 32'd7, 1'b0);
    wait_done(cycles, moved);
    tests_run++; if (cycles !== 34) begin tests_failed++; $display("[TB] FAIL abort_relatency: got %0d expected 34", cycles); end
    tests_run++; if ({hi, lo} !== 64'h2A) begin tests_failed++; $display("[TB] FAIL abort_reproduct: got %h expected 2a", {hi, lo}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] exp_p;
    int          cycles;
    logic        moved;
    ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
    exp_p = model(ra, rb, rs);
    start_op(32'd4, 32'd4, 1'b0);
    wait_done(cycles, moved);
    tests_run++; if (cycles !== 34) begin tests_failed++; $display("[TB] FAIL b2b_first_latency: got %0d expected 34", cycles); end
    tests_run++; if ({hi, lo} !== 64'h10) begin tests_failed++; $display("[TB] FAIL b2b_first_product: got %h expected 10", {hi, lo}); end
    a = ra; b = rb; sgn = rs; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_accept: got %b expected 1", busy); end
    tests_run++; if (lo !== 32'h10) begin tests_failed++; $display("[TB] FAIL b2b_hold: got %h expected 10", lo); end
    wait_done(cycles, moved);
    tests_run++; if (cycles !== 34) begin tests_failed++; $display("[TB] FAIL b2b_second_latency: got %0d expected 34", cycles); end
    tests_run++; if ({hi, lo} !== exp_p) begin tests_failed++; $display("[TB] FAIL b2b_second_product: got %h expected %h", {hi, lo}, exp_p); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_signed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
